// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared constants and types for the instruction-fetch slice.
//   XLEN_DEF      default datapath / address width
//   RESET_PC_DEF  default PC after reset
//   NOP_INSTR_DEF bubble instruction (addi x0,x0,0)
//   fetch_state_t fetch FSM encoding {FETCH, MISS, DISCARD}
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        MISS    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage : riscv_pkg

// File: rtl/fetch_ctrl_if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Priority: flush > stall > load > bubble.
// A flush or bubble writes the NOP instruction and clears valid; the PC
// fields keep their last value since they are meaningless while valid=0.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_i      replace contents with NOP, valid=0
//   stall_i      hold every field
//   load_i       capture instr_i / pc_i as a real instruction
//   instr_i      instruction word from the I-cache
//   pc_i         PC of instr_i
//   instr_o      IF/ID instruction
//   pc_o         IF/ID PC
//   pcplus4_o    IF/ID PC+4
//   valid_o      IF/ID holds a real instruction
// ----------------------------------------------------------------------------
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int          XLEN      = XLEN_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pcplus4_o,
    output logic            valid_o
);

    logic [31:0]     instr_d, instr_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic [XLEN-1:0] pcplus4_d, pcplus4_q;
    logic            valid_d, valid_q;

    // Next-state selection for the IF/ID fields.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall_i) begin
            instr_d   = instr_q;
            valid_d   = valid_q;
        end else if (load_i) begin
            instr_d   = instr_i;
            pc_d      = pc_i;
            pcplus4_d = pc_i + XLEN'(32'd4);
            valid_d   = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    // IF/ID storage with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule : if_id_reg

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
// IF stage plus IF/ID register. Owns the PC, issues I-cache fetches with a
// hold-until-valid handshake, parks redirects that arrive while a fetch is
// outstanding, and feeds the IF/ID register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stallF, stallD      hazard-unit stalls for PC and IF/ID
//   flushD              squash IF/ID (taken branch / jal)
//   redirect,redirect_pc PC redirect request and target
//   ic_req, ic_addr     fetch request / address to the I-cache
//   ic_valid, ic_rdata  I-cache response (same cycle on hit)
//   miss_stall          fetch is not delivering this cycle
//   pcF                 current fetch PC
//   instrD, pcD, pcplus4D, validD   IF/ID register outputs
// ----------------------------------------------------------------------------
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int               XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0]      NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ic_req,
    output logic [XLEN-1:0] ic_addr,
    input  logic            ic_valid,
    input  logic [31:0]     ic_rdata,
    output logic            miss_stall,
    output logic [XLEN-1:0] pcF,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcplus4D,
    output logic            validD
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            deliver_s;

    // The request stays up in every state: DISCARD leaves as soon as the
    // stale line returns, so there is never a cycle with nothing to ask for.
    assign ic_req  = 1'b1;
    // The PC only moves when the cache has answered (or on a redirect that
    // coincides with ic_valid), so pcF is also the stable fetch address.
    assign ic_addr = pc_q;
    assign pcF     = pc_q;

    // Stall is raised whenever no word is handed to ID: waiting for the
    // cache, or throwing away a stale line. A hit that closes a miss is a
    // delivery, so an N-cycle miss costs exactly N bubbles.
    assign miss_stall = (state_q == DISCARD) | (ic_req & ~ic_valid);

    // A word reaches ID only when it is valid, not stale, not overtaken by a
    // redirect, and the PC is free to advance past it.
    assign deliver_s = ic_valid & ~redirect & ~stallF & (state_q != DISCARD);

    // FSM, PC and parked-redirect next-state logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;

        case (state_q)
            FETCH: begin
                if (ic_valid) begin
                    state_d = FETCH;
                end else if (redirect) begin
                    state_d   = DISCARD;
                    pend_pc_d = redirect_pc;
                end else begin
                    state_d = MISS;
                end
            end
            MISS: begin
                if (ic_valid) begin
                    state_d = FETCH;
                end else if (redirect) begin
                    state_d   = DISCARD;
                    pend_pc_d = redirect_pc;
                end else begin
                    state_d = MISS;
                end
            end
            DISCARD: begin
                if (ic_valid) begin
                    state_d = FETCH;
                end else if (redirect) begin
                    state_d   = DISCARD;
                    pend_pc_d = redirect_pc;
                end else begin
                    state_d = DISCARD;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // A redirect may only move the PC once the outstanding request has
        // been answered; otherwise it was parked above.
        if (ic_valid && redirect) begin
            pc_d = redirect_pc;
        end else if (ic_valid && (state_q == DISCARD)) begin
            pc_d = pend_pc_q;
        end else if (stallF) begin
            pc_d = pc_q;
        end else if (miss_stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + XLEN'(32'd4);
        end
    end

    // Fetch FSM state, PC and parked redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flushD),
        .stall_i   (stallD),
        .load_i    (deliver_s),
        .instr_i   (ic_rdata),
        .pc_i      (pc_q),
        .instr_o   (instrD),
        .pc_o      (pcD),
        .pcplus4_o (pcplus4D),
        .valid_o   (validD)
    );

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stallF, stallD, flushD, redirect;
    logic [31:0] redirect_pc;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_rdata;
    logic        miss_stall;
    logic [31:0] pcF, instrD, pcD, pcplus4D;
    logic        validD;

    int total = 0;
    int bad   = 0;

    fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stallF      (stallF),
        .stallD      (stallD),
        .flushD      (flushD),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ic_req      (ic_req),
        .ic_addr     (ic_addr),
        .ic_valid    (ic_valid),
        .ic_rdata    (ic_rdata),
        .miss_stall  (miss_stall),
        .pcF         (pcF),
        .instrD      (instrD),
        .pcD         (pcD),
        .pcplus4D    (pcplus4D),
        .validD      (validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: word content is a fixed function of address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign ic_rdata = mem(ic_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sf, sd, fd, rd;
        logic [31:0] rpc;
        logic        v;
        logic        exp_ms;
        logic [31:0] exp_pc;
        logic [31:0] exp_pcd;
        logic        exp_vd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic sf, input logic sd, input logic fd,
                                input logic rd, input logic [31:0] rpc, input logic v,
                                input logic ms, input logic [31:0] pc,
                                input logic [31:0] pcd, input logic vd);
        vec_t t;
        t.sf = sf; t.sd = sd; t.fd = fd; t.rd = rd; t.rpc = rpc; t.v = v;
        t.exp_ms = ms; t.exp_pc = pc; t.exp_pcd = pcd; t.exp_vd = vd;
        return t;
    endfunction

    logic [31:0] cur_pc;
    logic [31:0] last_pcd;

    initial begin
        // sf sd fd rd rpc v | ms pc(after edge) pcD vD
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 0, 32'h4,         32'h0,         1)); // 0
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 0, 32'h8,         32'h4,         1));
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 0, 32'hC,         32'h8,         1));
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 0, 32'h10,        32'hC,         1));
        tbl.push_back(mk(0,0,0,0,32'h0,        0, 1, 32'h10,        32'h0,         0)); // miss x3
        tbl.push_back(mk(0,0,0,0,32'h0,        0, 1, 32'h10,        32'h0,         0));
        tbl.push_back(mk(0,0,0,0,32'h0,        0, 1, 32'h10,        32'h0,         0));
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 0, 32'h14,        32'h10,        1)); // fill
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 0, 32'h18,        32'h14,        1));
        tbl.push_back(mk(1,1,0,0,32'h0,        1, 0, 32'h18,        32'h14,        1)); // stall x2
        tbl.push_back(mk(1,1,0,0,32'h0,        1, 0, 32'h18,        32'h14,        1));
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 0, 32'h1C,        32'h18,        1));
        tbl.push_back(mk(1,1,1,0,32'h0,        1, 0, 32'h1C,        32'h0,         0)); // flush>stall
        tbl.push_back(mk(1,0,0,1,32'h100,      1, 0, 32'h100,       32'h0,         0)); // redirect>stallF
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 0, 32'h104,       32'h100,       1));
        tbl.push_back(mk(0,0,0,1,32'h40,       1, 0, 32'h40,        32'h0,         0));
        tbl.push_back(mk(0,0,0,0,32'h0,        0, 1, 32'h40,        32'h0,         0)); // miss @40
        tbl.push_back(mk(0,0,0,1,32'h200,      0, 1, 32'h40,        32'h0,         0)); // -> DISCARD
        tbl.push_back(mk(0,0,0,0,32'h0,        0, 1, 32'h40,        32'h0,         0));
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 1, 32'h200,       32'h0,         0)); // stale dropped
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 0, 32'h204,       32'h200,       1));
        tbl.push_back(mk(0,0,0,1,32'h300,      0, 1, 32'h204,       32'h0,         0)); // FETCH->DISCARD
        tbl.push_back(mk(0,0,0,1,32'h400,      0, 1, 32'h204,       32'h0,         0)); // newer wins
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 1, 32'h400,       32'h0,         0));
        tbl.push_back(mk(0,0,0,0,32'h0,        0, 1, 32'h400,       32'h0,         0)); // miss @400
        tbl.push_back(mk(0,0,0,1,32'h500,      1, 0, 32'h500,       32'h0,         0)); // fill+redirect
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 0, 32'h504,       32'h500,       1));
        tbl.push_back(mk(0,0,0,1,32'hFFFF_FFFC,1, 0, 32'hFFFF_FFFC, 32'h0,         0));
        tbl.push_back(mk(0,0,0,0,32'h0,        1, 0, 32'h0,         32'hFFFF_FFFC, 1)); // wrap

        rst_n = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0; ic_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pcF", pcF, 32'h0);
        chk("rst_instrD", instrD, NOP);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_pcplus4D", pcplus4D, 32'h0);
        chk("rst_validD", {31'd0, validD}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cur_pc   = 32'h0;
        last_pcd = 32'h0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (i != 0) @(negedge clk);
            stallF = tbl[i].sf; stallD = tbl[i].sd; flushD = tbl[i].fd;
            redirect = tbl[i].rd; redirect_pc = tbl[i].rpc; ic_valid = tbl[i].v;
            #1;
            chk($sformatf("v%0d_miss_stall", i), {31'd0, miss_stall}, {31'd0, tbl[i].exp_ms});
            chk($sformatf("v%0d_ic_addr", i), ic_addr, cur_pc);
            chk($sformatf("v%0d_ic_req", i), {31'd0, ic_req}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pcF", i), pcF, tbl[i].exp_pc);
            chk($sformatf("v%0d_validD", i), {31'd0, validD}, {31'd0, tbl[i].exp_vd});
            if (tbl[i].exp_vd) begin
                chk($sformatf("v%0d_instrD", i), instrD, mem(tbl[i].exp_pcd));
                chk($sformatf("v%0d_pcD", i), pcD, tbl[i].exp_pcd);
                chk($sformatf("v%0d_pcplus4D", i), pcplus4D, tbl[i].exp_pcd + 32'd4);
            end else begin
                chk($sformatf("v%0d_instrD", i), instrD, NOP);
            end
            cur_pc = tbl[i].exp_pc;
        end

        // Reset in the middle of a miss: outputs must drop without a clock edge.
        @(negedge clk);
        stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; redirect = 1'b0; ic_valid = 1'b1;
        @(posedge clk);                 // pcF 0 -> 4, instrD = mem(0)
        @(negedge clk);
        ic_valid = 1'b0;                // miss at 0x4
        @(posedge clk);
        #3;
        chk("pre_rst_pcF", pcF, 32'h4);
        rst_n = 1'b0;
        #1;
        chk("arst_pcF", pcF, 32'h0);
        chk("arst_ic_addr", ic_addr, 32'h0);
        chk("arst_instrD", instrD, NOP);
        chk("arst_pcD", pcD, 32'h0);
        chk("arst_validD", {31'd0, validD}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ic_valid = 1'b1;
        #1;
        chk("rel_miss_stall", {31'd0, miss_stall}, 32'd0);
        chk("rel_ic_addr", ic_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("rel_pcF", pcF, 32'h4);
        chk("rel_instrD", instrD, mem(32'h0));
        chk("rel_validD", {31'd0, validD}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_ctrl
